evm_vote_ledger: RTL and testbench
==================================

Name: evm_vote_ledger

Overview:
- Consumer end of the voter-ID database write interface in the EVM.
- Accepts the database's `write` strobe with the validated voter ID and address, and rejects voters who have already voted.
- Opens a ballot window, records one candidate selection, marks the voter as having voted, and keeps per-candidate tallies.
- Tallies can be read back with 1-cycle latency.

Parameters:
- NUM_CAND, 4, number of candidates; candidate select is 2 bits wide.
- TALLY_W, 8, width of each tally counter; counters saturate at 2^TALLY_W-1.
- TIMEOUT, 50, clock cycles the ballot stays open without a cast before it aborts.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- write  input  1  single-cycle strobe from the ID database: voter validated.
- valid_voter_address  input  4  voter slot index 0..15.
- valid_voter  input  5  voter ID of the validated voter.
- cast  input  1  single-cycle vote-button strobe.
- candidate  input  2  candidate selected; sampled when cast=1.
- read_enable  input  1  tally read request.
- read_sel  input  2  candidate tally to read.
- ballot_open  output  1  high while waiting for a cast.
- vote_done  output  1  1-cycle pulse when a vote is committed.
- dup_reject  output  1  1-cycle pulse when the `write` is for an address that has already voted.
- timeout  output  1  1-cycle pulse when the ballot aborts.
- cur_voter  output  5  ID of the voter whose ballot is open (latched).
- tally_out  output  TALLY_W  registered tally of read_sel.
- tally_valid  output  1  high the cycle after read_enable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Voted-flag vector (16 bits) cleared.
  - All tallies, the timer, cur_voter and tally_out set to 0.
  - Every output is 0.
- FSM states: IDLE, BALLOT, COMMIT.
- IDLE:
  - On write=1 with voted[addr]=1: pulse dup_reject next cycle and stay in IDLE.
  - On write=1 with voted[addr]=0: latch addr and valid_voter into cur_voter, clear the timer, go to BALLOT. ballot_open rises the next cycle.
  - cast is ignored in IDLE.
- BALLOT:
  - ballot_open=1 and the timer increments every cycle.
  - On cast=1: latch candidate, go to COMMIT.
  - If the timer reaches TIMEOUT-1 with no cast: pulse timeout, return to IDLE. The voter is not marked and can retry.
  - A cast in the same cycle as the timeout boundary wins over the timeout.
  - write strobes arriving in BALLOT are ignored; no dup_reject is generated.
- COMMIT (one cycle):
  - Set voted[latched addr]=1.
  - Increment tally[latched candidate], saturating at all-ones.
  - Pulse vote_done, drop ballot_open, return to IDLE.
  - Latency from cast to vote_done is 2 cycles.
- cur_voter holds its last value after return to IDLE until the next accepted write.
- Read port:
  - Independent of the FSM.
  - read_enable=1 registers tally[read_sel] into tally_out and sets tally_valid=1 on the next cycle; otherwise tally_valid=0.
  - A read in the same cycle as COMMIT returns the pre-increment value.
- Reset mid-BALLOT discards the ballot; no flag or tally changes.

Optional Feature:
- Macro: EVM_AUDIT_EN.
- When defined:
  - Adds output total_votes (width TALLY_W+2), which increments on every vote_done and never saturates below its full range.
  - Adds output last_voter (5 bits), loaded with cur_voter on every vote_done.
  - Both reset to 0.
- When undefined:
  - These ports and registers do not exist.
  - All other behaviour is identical.

Test Plan:
1. Reset, write with addr=0 and voter=00000, cast with candidate=2 three cycles later:
   - ballot_open=1 one cycle after write.
   - vote_done pulses 2 cycles after cast.
   - read_sel=2 returns tally_out=1 with tally_valid=1.
2. Repeat write with addr=0 after scenario 1 -> dup_reject pulses, state stays IDLE, no tally changes.
3. write with addr=2 and voter=00010, no cast:
   - timeout pulses exactly TIMEOUT cycles after ballot_open rises.
   - A later write with addr=2 is accepted (no dup_reject).
4. cast in IDLE, and a second write (addr=5) during an open ballot -> both ignored; tallies and flags unchanged.
5. 256 votes for candidate 1 (write then cast each time; cycle through 16 addresses, pulsing rst_n is not allowed so use a bench-forced flag clear or TALLY_W=4 with 20 votes) -> tally saturates at 2^TALLY_W-1.
6. Assert rst_n=0 mid-BALLOT:
   - All outputs are 0 asynchronously.
   - After release, voted[addr] is still 0 and all tallies are 0.
   - With EVM_AUDIT_EN, total_votes=0 and last_voter=0.

Source files
------------

// File: rtl/evm_vote_ledger.sv
// evm_vote_ledger: consumer end of the voter-ID database write port.
// One ballot is open at a time. Each voter slot can commit one vote,
// and each candidate has a saturating tally that is read back with a
// one-cycle latency.
// Optional build macro EVM_AUDIT_EN adds the total_votes and last_voter
// audit outputs.

// Per-candidate saturating tally counter (one instance per candidate)
module evm_tally_cnt #(
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [TALLY_W-1:0] cnt
);
  // count commits, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module evm_vote_ledger #(
  parameter int NUM_CAND = 4,
  parameter int TALLY_W  = 8,
  parameter int TIMEOUT  = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write,
  input  logic [3:0]                  valid_voter_address,
  input  logic [4:0]                  valid_voter,
  input  logic                        cast,
  input  logic [$clog2(NUM_CAND)-1:0] candidate,
  input  logic                        read_enable,
  input  logic [$clog2(NUM_CAND)-1:0] read_sel,
  output logic                        ballot_open,
  output logic                        vote_done,
  output logic                        dup_reject,
  output logic                        timeout,
  output logic [4:0]                  cur_voter,
  output logic [TALLY_W-1:0]          tally_out,
  output logic                        tally_valid
`ifdef EVM_AUDIT_EN
  ,
  output logic [TALLY_W+1:0]          total_votes,
  output logic [4:0]                  last_voter
`endif
);
  localparam int CW    = $clog2(NUM_CAND);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BALLOT, COMMIT} state_t;

  // slot and selection of the ballot currently in flight
  typedef struct packed {
    logic [3:0]    addr;
    logic [CW-1:0] cand;
  } ballot_t;

  state_t                            state, state_nxt;
  ballot_t                           bal;
  logic [15:0]                       voted;
  logic [TMR_W-1:0]                  timer;
  logic                              accept, dup, expire, commit;
  logic [NUM_CAND-1:0]               inc;
  logic [NUM_CAND-1:0][TALLY_W-1:0]  tally;

  assign ballot_open = (state == BALLOT);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and single-cycle event decode; a cast beats the timeout
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dup       = 1'b0;
    expire    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (write) begin
          if (voted[valid_voter_address]) begin
            dup = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = BALLOT;
          end
        end
      end
      BALLOT: begin
        if (cast) begin
          state_nxt = COMMIT;
        end else if (timer == TMR_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ballot latches, voted flags, timer and registered event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bal        <= '0;
      cur_voter  <= '0;
      voted      <= '0;
      timer      <= '0;
      dup_reject <= 1'b0;
      timeout    <= 1'b0;
      vote_done  <= 1'b0;
    end else begin
      if (accept) begin
        bal.addr  <= valid_voter_address;
        cur_voter <= valid_voter;
        timer     <= '0;
      end else if (state == BALLOT) begin
        timer <= timer + 1'b1;
      end
      if (state == BALLOT && cast) bal.cand <= candidate;
      if (commit) voted[bal.addr] <= 1'b1;
      dup_reject <= dup;
      timeout    <= expire;
      vote_done  <= commit;
    end
  end

  // one tally counter per candidate, bumped in COMMIT
  for (genvar i = 0; i < NUM_CAND; i++) begin : g_tally
    assign inc[i] = commit && (bal.cand == CW'(i));
    evm_tally_cnt #(.TALLY_W(TALLY_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .cnt   (tally[i])
    );
  end

  // read port; samples before this cycle's commit lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tally_out   <= '0;
      tally_valid <= 1'b0;
    end else begin
      tally_valid <= read_enable;
      if (read_enable) tally_out <= tally[read_sel];
    end
  end

`ifdef EVM_AUDIT_EN
  // audit trail: running vote count and most recent committed voter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_votes <= '0;
      last_voter  <= '0;
    end else if (commit) begin
      total_votes <= total_votes + 1'b1;
      last_voter  <= cur_voter;
    end
  end
`endif

endmodule

// File: tb/tb_evm_vote_ledger.sv
// Bench for evm_vote_ledger: directed scenarios plus a random run, all
// checked against a transaction-level model (flags, tallies, counters).
module tb_evm_vote_ledger;
  localparam int NC  = 4;
  localparam int TW  = 3;
  localparam int TO  = 50;
  localparam int SAT = (1 << TW) - 1;
  localparam int AW  = TW + 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          write = 1'b0, cast = 1'b0, read_enable = 1'b0;
  logic [3:0]    addr = '0;
  logic [4:0]    voter = '0;
  logic [1:0]    cand = '0, rsel = '0;
  logic          ballot_open, vote_done, dup_reject, timeout, tally_valid;
  logic [4:0]    cur_voter;
  logic [TW-1:0] tally_out;
`ifdef EVM_AUDIT_EN
  logic [AW-1:0] total_votes;
  logic [4:0]    last_voter;
`endif

  evm_vote_ledger #(.NUM_CAND(NC), .TALLY_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .valid_voter_address(addr),
    .valid_voter(voter), .cast(cast), .candidate(cand),
    .read_enable(read_enable), .read_sel(rsel), .ballot_open(ballot_open),
    .vote_done(vote_done), .dup_reject(dup_reject), .timeout(timeout),
    .cur_voter(cur_voter), .tally_out(tally_out), .tally_valid(tally_valid)
`ifdef EVM_AUDIT_EN
    , .total_votes(total_votes), .last_voter(last_voter)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model
  bit       m_voted [16];
  int       m_tally [NC];
  logic [4:0] m_cur;
  int       m_total;
  logic [4:0] m_last;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    foreach (m_voted[i]) m_voted[i] = 1'b0;
    foreach (m_tally[i]) m_tally[i] = 0;
    m_cur = '0; m_total = 0; m_last = '0;
  endtask

  task automatic do_reset();
    write = 0; cast = 0; read_enable = 0; addr = '0; voter = '0; cand = '0; rsel = '0;
    rst_n = 1'b0;
    model_clear();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic open_ballot(input logic [3:0] a, input logic [4:0] v, output bit ok);
    write = 1; addr = a; voter = v;
    cyc();
    write = 0;
    if (m_voted[a]) begin
      ok = 0;
      checks++;
      if (dup_reject !== 1'b1 || ballot_open !== 1'b0) begin
        failures++;
        $display("FAIL dup_pulse addr=%0d: dup_reject=%b ballot_open=%b, want 1 0", a, dup_reject, ballot_open);
      end
      cyc();
      checks++;
      if (dup_reject !== 1'b0) begin
        failures++;
        $display("FAIL dup_width: dup_reject=%b want 0", dup_reject);
      end
    end else begin
      ok = 1;
      m_cur = v;
      checks++;
      if (ballot_open !== 1'b1 || dup_reject !== 1'b0 || cur_voter !== v) begin
        failures++;
        $display("FAIL ballot_open addr=%0d: open=%b dup=%b cur_voter=%0d, want 1 0 %0d",
                 a, ballot_open, dup_reject, cur_voter, v);
      end
    end
  endtask

  // cast d cycles after the ballot opened; reads the same tally during COMMIT
  task automatic cast_vote(input logic [1:0] c, input int d, input logic [3:0] a);
    repeat (d) cyc();
    checks++;
    if (ballot_open !== 1'b1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL pre_cast: ballot_open=%b timeout=%b want 1 0", ballot_open, timeout);
    end
    cast = 1; cand = c;
    cyc();
    cast = 0;
    checks++;
    if (ballot_open !== 1'b0 || vote_done !== 1'b0) begin
      failures++;
      $display("FAIL commit_cycle: ballot_open=%b vote_done=%b want 0 0", ballot_open, vote_done);
    end
    read_enable = 1; rsel = c;
    cyc();
    read_enable = 0;
    checks++;
    if (vote_done !== 1'b1) begin
      failures++;
      $display("FAIL vote_done latency: vote_done=%b want 1", vote_done);
    end
    checks++;
    if (tally_valid !== 1'b1 || tally_out !== TW'(m_tally[c])) begin
      failures++;
      $display("FAIL read_in_commit cand=%0d: valid=%b tally=%0d want 1 %0d",
               c, tally_valid, tally_out, m_tally[c]);
    end
    m_voted[a] = 1'b1;
    if (m_tally[c] < SAT) m_tally[c]++;
    m_total++;
    m_last = m_cur;
`ifdef EVM_AUDIT_EN
    checks++;
    if (total_votes !== AW'(m_total) || last_voter !== m_last) begin
      failures++;
      $display("FAIL audit: total=%0d last=%0d want %0d %0d", total_votes, last_voter, m_total, m_last);
    end
`endif
    cyc();
    checks++;
    if (vote_done !== 1'b0) begin
      failures++;
      $display("FAIL vote_done_width: vote_done=%b want 0", vote_done);
    end
  endtask

  // ballot already open in the current cycle; let it expire
  task automatic run_timeout();
    bit bad = 0;
    for (int k = 1; k < TO; k++) begin
      cyc();
      if (ballot_open !== 1'b1 || timeout !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL timeout_early: ballot closed or timeout before %0d cycles", TO);
    end
    cyc();
    checks++;
    if (timeout !== 1'b1 || ballot_open !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: timeout=%b ballot_open=%b want 1 0", timeout, ballot_open);
    end
    cyc();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width: timeout=%b want 0", timeout);
    end
  endtask

  task automatic read_all();
    for (int s = 0; s < NC; s++) begin
      read_enable = 1; rsel = 2'(s);
      cyc();
      read_enable = 0;
      checks++;
      if (tally_valid !== 1'b1 || tally_out !== TW'(m_tally[s])) begin
        failures++;
        $display("FAIL tally_read cand=%0d: valid=%b tally=%0d want 1 %0d", s, tally_valid, tally_out, m_tally[s]);
      end
    end
    cyc();
    checks++;
    if (tally_valid !== 1'b0) begin
      failures++;
      $display("FAIL tally_valid_idle: tally_valid=%b want 0", tally_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ballot_open, vote_done, dup_reject, timeout, cur_voter, tally_out, tally_valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: open=%b done=%b dup=%b to=%b cur=%0d tally=%0d tv=%b want all 0",
               ballot_open, vote_done, dup_reject, timeout, cur_voter, tally_out, tally_valid);
    end
    do_reset();
    read_all();
  endtask

  task automatic test_basic_vote();
    bit ok;
    do_reset();
    open_ballot(4'd0, 5'd0, ok);
    if (ok) cast_vote(2'd2, 2, 4'd0);
    read_all();
  endtask

  task automatic test_duplicate();
    bit ok;
    open_ballot(4'd0, 5'd9, ok);
    checks++;
    if (ok || cur_voter !== 5'd0 || ballot_open !== 1'b0) begin
      failures++;
      $display("FAIL dup_state: ok=%b cur_voter=%0d open=%b want 0 0 0", ok, cur_voter, ballot_open);
    end
    read_all();
  endtask

  task automatic test_timeout();
    bit ok;
    open_ballot(4'd2, 5'd2, ok);
    if (ok) run_timeout();
    open_ballot(4'd2, 5'd2, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL retry_after_timeout: accepted=%b want 1", ok);
    end
    if (ok) cast_vote(2'd1, TO - 1, 4'd2);
    read_all();
  endtask

  task automatic test_ignored();
    bit ok;
    cast = 1; cand = 2'd3;
    cyc();
    cast = 0;
    cyc();
    checks++;
    if (ballot_open !== 1'b0 || vote_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_cast: open=%b done=%b want 0 0", ballot_open, vote_done);
    end
    open_ballot(4'd4, 5'd4, ok);
    write = 1; addr = 4'd5; voter = 5'd5;
    cyc();
    addr = 4'd0; voter = 5'd7;
    cyc();
    write = 0;
    checks++;
    if (dup_reject !== 1'b0 || cur_voter !== 5'd4 || ballot_open !== 1'b1) begin
      failures++;
      $display("FAIL write_in_ballot: dup=%b cur=%0d open=%b want 0 4 1", dup_reject, cur_voter, ballot_open);
    end
    if (ok) cast_vote(2'd3, 0, 4'd4);
    open_ballot(4'd5, 5'd5, ok);
    if (ok) cast_vote(2'd0, 1, 4'd5);
    read_all();
  endtask

  task automatic test_saturate();
    bit ok;
    do_reset();
    for (int i = 0; i < SAT + 3; i++) begin
      open_ballot(4'(i), 5'(i + 16), ok);
      if (ok) cast_vote(2'd1, 0, 4'(i));
    end
    read_enable = 1; rsel = 2'd1;
    cyc();
    read_enable = 0;
    checks++;
    if (tally_out !== TW'(SAT)) begin
      failures++;
      $display("FAIL saturate: tally=%0d want %0d", tally_out, SAT);
    end
    read_all();
  endtask

  task automatic test_reset_mid_ballot();
    bit ok;
    open_ballot(4'd12, 5'd30, ok);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ballot_open, vote_done, dup_reject, timeout, cur_voter, tally_out, tally_valid} !== '0) begin
      failures++;
      $display("FAIL reset_mid: open=%b done=%b dup=%b to=%b cur=%0d tally=%0d tv=%b want all 0",
               ballot_open, vote_done, dup_reject, timeout, cur_voter, tally_out, tally_valid);
    end
`ifdef EVM_AUDIT_EN
    checks++;
    if (total_votes !== '0 || last_voter !== '0) begin
      failures++;
      $display("FAIL reset_audit: total=%0d last=%0d want 0 0", total_votes, last_voter);
    end
`endif
    model_clear();
    cyc();
    rst_n = 1'b1;
    cyc();
    read_all();
    open_ballot(4'd12, 5'd30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_flag: addr 12 not accepted after reset");
    end
    if (ok) cast_vote(2'd3, 4, 4'd12);
  endtask

  task automatic test_random();
    bit ok;
    int op, d;
    logic [3:0] a;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      if (op < 7) begin
        open_ballot(a, 5'($urandom_range(0, 31)), ok);
        d = ($urandom_range(0, 3) == 0) ? TO - 1 : $urandom_range(0, 5);
        if (ok) cast_vote(2'($urandom_range(0, NC - 1)), d, a);
      end else if (op < 8) begin
        open_ballot(a, 5'($urandom_range(0, 31)), ok);
        if (ok) run_timeout();
      end else begin
        read_all();
      end
    end
    read_all();
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_duplicate();
    test_timeout();
    test_ignored();
    test_saturate();
    test_reset_mid_ballot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
